// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the round-robin memory read arbiter.
// The memory answers a fixed MEM_LATENCY cycles after each read strobe.
package mem_arb_pkg;

    localparam int MEM_LATENCY = 9;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Circular successor of a requester id.
    function automatic int next_rr(input int id, input int n);
        return (id + 1 == n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the read arbiter.
// master = the arbiter, slave = the requesters plus the memory.
interface mem_read_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // A request transfers in the cycle where req_valid[i] and req_ready[i]
    // are both high; req_valid/req_addr stay stable until then. rsp_valid
    // and mem_rvalid are single-cycle strobes with no ready back-pressure.
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    mem_arvalid;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_data;
    logic                    mem_rvalid;

    modport master (
        input  req_valid, req_addr, mem_data, mem_rvalid,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_arvalid, mem_addr
    );

    modport slave (
        output req_valid, req_addr, mem_data, mem_rvalid,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_arvalid, mem_addr
    );

endinterface

// File: rtl/mem_read_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = idx;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing a single-outstanding memory read port between
// N_REQ refill engines, with a watchdog that turns a lost rvalid into an error.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_read_arbiter_if.master       bus,
    output arb_state_t               state_o,
    output logic [$clog2(N_REQ)-1:0] rr_ptr_o
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic              arvalid_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [N_REQ-1:0]  gnt_onehot;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic [ADDR_W-1:0] win_addr;
    logic [N_REQ-1:0]  id_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        id_onehot       = '0;
        id_onehot[id_q] = 1'b1;
    end

    // Count of WAIT cycles including the current one.
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        addr_q    <= win_addr;
                        id_q      <= gnt_id;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    arvalid_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // rvalid wins over the watchdog when both land together.
                    if (bus.mem_rvalid) begin
                        rsp_data_q  <= bus.mem_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= id_onehot;
                        state_q     <= ST_RESP;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= id_onehot;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= '0;
                    rr_ptr_q    <= ID_W'(next_rr(int'(id_q), N_REQ));
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Acceptance is combinational in IDLE; held off while reset is applied.
    assign bus.req_ready   = (rst_n && state_q == ST_IDLE) ? gnt_onehot : '0;
    assign bus.mem_arvalid = arvalid_q;
    assign bus.mem_addr    = addr_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_data    = rsp_data_q;

    assign state_o  = state_q;
    assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized scoreboard bench for mem_read_arbiter with a behavioural
// requester/memory environment and a transaction-level reference model.
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    localparam int N_REQ   = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 15;
    localparam int EXP_W   = 32 + 8 + 1 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_read_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    arb_state_t               state_o;
    logic [$clog2(N_REQ)-1:0] rr_ptr_o;

    mem_read_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .state_o  (state_o),
        .rr_ptr_o (rr_ptr_o)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [EXP_W-1:0]  exp_q[$];
    int                dut_grants[$];
    logic [ADDR_W-1:0] pend_q[N_REQ][$];
    bit                acc_seen[N_REQ];

    int                free_cyc     = 0;
    int                next_ptr     = 0;
    int                arv_cyc      = -1;
    int                last_acc_cyc = -100;
    logic [ADDR_W-1:0] arv_addr     = '0;
    logic [ADDR_W-1:0] model_addr   = '0;
    bit                drop_model   = 1'b0;
    bit                drop_mem     = 1'b0;
    bit                spur_pulse   = 1'b0;

    function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(a + ADDR_W'(k));
        return d;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'($urandom_range(0, 65535) * 8);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    assign bus.mem_data = line_of(bus.mem_addr);

    initial begin
        int due;
        due = -1;
        bus.mem_rvalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (!rst_n) begin
                due = -1;
            end else begin
                if (bus.mem_arvalid) begin
                    if (drop_mem) drop_mem = 1'b0;
                    else          due = cyc + MEM_LATENCY;
                end
                if (due == cyc) begin
                    bus.mem_rvalid = 1'b1;
                    due = -1;
                end
                if (spur_pulse) begin
                    spur_pulse     = 1'b0;
                    bus.mem_rvalid = 1'b1;
                end
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    always @(negedge clk) begin
        logic [N_REQ-1:0]  exp_ready;
        logic [N_REQ-1:0]  exp_rv;
        logic [EXP_W-1:0]  item;
        logic [ADDR_W-1:0] addr;
        int win, rc, p;
        if (rst_n) begin
            exp_ready = '0;
            win = -1;
            if (cyc >= free_cyc) begin
                for (int k = 0; k < N_REQ; k++) begin
                    p = (next_ptr + k) % N_REQ;
                    if (win < 0 && ((bus.req_valid >> p) & N_REQ'(1)) != 0) win = p;
                end
            end
            if (win >= 0) exp_ready = N_REQ'(1) << win;
            chk("req_ready", bus.req_ready, exp_ready);
            for (int i = 0; i < N_REQ; i++)
                if (((bus.req_ready >> i) & N_REQ'(1)) != 0) dut_grants.push_back(i);

            if (win >= 0) begin
                addr = bus.req_addr[win*ADDR_W +: ADDR_W];
                if (drop_model) begin
                    drop_model = 1'b0;
                    rc   = cyc + TIMEOUT + 2;
                    item = {32'(rc), 8'(win), 1'b1, {DATA_W{1'b0}}};
                end else begin
                    rc   = cyc + 11;
                    item = {32'(rc), 8'(win), 1'b0, line_of(addr)};
                end
                exp_q.push_back(item);
                free_cyc      = rc + 1;
                arv_cyc       = cyc + 1;
                arv_addr      = addr;
                next_ptr      = (win + 1) % N_REQ;
                acc_seen[win] = 1'b1;
                last_acc_cyc  = cyc;
            end

            if (cyc == arv_cyc) model_addr = arv_addr;
            chk("mem_arvalid", bus.mem_arvalid, cyc == arv_cyc);
            chk("mem_addr", bus.mem_addr, model_addr);

            exp_rv = '0;
            if (exp_q.size() > 0) begin
                item = exp_q[0];
                if (int'(item[EXP_W-1 -: 32]) == cyc)
                    exp_rv = N_REQ'(1) << int'(item[DATA_W+1 +: 8]);
            end
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_q.size() > 0) begin
                item = exp_q[0];
                if (int'(item[EXP_W-1 -: 32]) <= cyc) begin
                    void'(exp_q.pop_front());
                    if (bus.rsp_valid == exp_rv) begin
                        chk("rsp_err", bus.rsp_err, item[DATA_W]);
                        chk("rsp_data", bus.rsp_data, item[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycle();
        @(posedge clk);
        #2;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_seen[i]) begin
                acc_seen[i]      = 1'b0;
                bus.req_valid[i] = 1'b0;
            end
            if (!bus.req_valid[i] && pend_q[i].size() > 0) begin
                bus.req_valid[i] = 1'b1;
                bus.req_addr[i*ADDR_W +: ADDR_W] = pend_q[i].pop_front();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, '0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, '0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        chk({tag, "_mem_arvalid"}, bus.mem_arvalid, 1'b0);
        chk({tag, "_rsp_data"}, bus.rsp_data, '0);
        chk({tag, "_mem_addr"}, bus.mem_addr, '0);
        chk({tag, "_state"}, state_o, ST_IDLE);
        chk({tag, "_rr_ptr"}, rr_ptr_o, '0);
    endtask

    // Asserts reset at the current time, holds it, checks outputs, releases.
    task automatic reset_dut(input string tag);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_q[i].delete();
            acc_seen[i] = 1'b0;
        end
        exp_q.delete();
        drop_model = 1'b0;
        drop_mem   = 1'b0;
        spur_pulse = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk);
        #2;
        free_cyc   = 0;
        next_ptr   = 0;
        arv_cyc    = -1;
        model_addr = '0;
        rst_n      = 1'b1;
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() > 0) || (bus.req_valid != '0) || (cyc < free_cyc);
        for (int i = 0; i < N_REQ; i++) if (pend_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy() && n < 3000) begin
            run_cycle();
            n++;
        end
        if (busy()) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int issued, guard, n;
        bus.req_valid = '0;
        bus.req_addr  = '0;

        reset_dut("reset");

        // Single request from port 0.
        pend_q[0].push_back(ADDR_W'('h10));
        drain("single");

        // Simultaneous requests right after reset: port 0 first.
        reset_dut("reset2");
        dut_grants.delete();
        pend_q[0].push_back(ADDR_W'('h00));
        pend_q[1].push_back(ADDR_W'('h08));
        drain("simul");
        chk("simul_count", dut_grants.size(), 2);
        if (dut_grants.size() == 2) begin
            chk("simul_first", dut_grants[0], 0);
            chk("simul_second", dut_grants[1], 1);
        end

        // Fairness: both ports request back-to-back.
        dut_grants.delete();
        for (int j = 0; j < 2; j++) begin
            pend_q[0].push_back(rand_addr());
            pend_q[1].push_back(rand_addr());
        end
        drain("fair");
        chk("fair_count", dut_grants.size(), 4);
        for (int j = 0; j < dut_grants.size() && j < 4; j++)
            chk($sformatf("fair_grant%0d", j), dut_grants[j], j % 2);

        // Timeout, then a normal request.
        drop_model = 1'b1;
        drop_mem   = 1'b1;
        pend_q[$urandom_range(0, N_REQ-1)].push_back(rand_addr());
        drain("timeout");
        pend_q[$urandom_range(0, N_REQ-1)].push_back(rand_addr());
        drain("after_timeout");

        // Spurious rvalid while idle.
        spur_pulse = 1'b1;
        repeat (4) run_cycle();
        chk("spur_state", state_o, ST_IDLE);
        chk("spur_rr_ptr", rr_ptr_o, next_ptr);

        // Reset five cycles after acceptance.
        last_acc_cyc = -100;
        pend_q[1].push_back(rand_addr());
        n = 0;
        while (!(last_acc_cyc >= 0 && cyc == last_acc_cyc + 5) && n < 100) begin
            run_cycle();
            n++;
        end
        chk("midrst_reached", n < 100, 1'b1);
        reset_dut("midrst");
        repeat (15) run_cycle();
        chk("midrst_state", state_o, ST_IDLE);
        chk("midrst_rr_ptr", rr_ptr_o, '0);

        // Random traffic with occasional dropped responses.
        issued = 0;
        guard  = 0;
        while (issued < 24 && guard < 5000) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pend_q[i].size() == 0 && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    pend_q[i].push_back(rand_addr());
                    issued++;
                end
            end
            if (exp_q.size() == 0 && cyc >= free_cyc && !drop_model && $urandom_range(0, 7) == 0) begin
                drop_model = 1'b1;
                drop_mem   = 1'b1;
            end
            run_cycle();
            guard++;
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
